// File: rtl/lane_timer_pkg.sv
// lane_timer_pkg
//   Shared definitions for the lane timer block:
//   - lane_state_e : per-lane FSM state encoding (IDLE, RUN, DONE)
//   - DEFAULT_*    : default values of the lane_timer parameters
package lane_timer_pkg;

    localparam int DEFAULT_LANES     = 2;
    localparam int DEFAULT_TICK_DIV  = 100000;
    localparam int DEFAULT_CNT_W     = 14;
    localparam int DEFAULT_MAX_COUNT = 9999;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } lane_state_e;

endpackage

// File: rtl/lane_tick_prescaler.sv
// lane_tick_prescaler
//   Divides clk down to one count unit per TICK_DIV cycles for a single lane.
//   Ports:
//     clk   - rising-edge clock
//     reset - asynchronous, active-high reset
//     run   - count enable; while low the divider is held at zero
//     tick  - high in the last cycle of each TICK_DIV period
module lane_tick_prescaler
    import lane_timer_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int               DIV_W = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] LAST  = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    // Dropping run clears the divider on the following edge, so a lane that
    // enters RUN always starts a fresh period from zero.
    always_comb begin
        div_d = '0;
        if (run) begin
            if (div_q == LAST) begin
                div_d = '0;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // Decoded from the register only, so there is no path from run to tick.
    // It can be high for one cycle after leaving RUN; the lane qualifies it
    // with its own state.
    assign tick = (div_q == LAST);

endmodule

// File: rtl/lane_timer.sv
// lane_timer
//   LANES independent stopwatch lanes. Each lane runs IDLE -> RUN -> DONE,
//   counts units of TICK_DIV clk cycles while in RUN (saturating at
//   MAX_COUNT) and remembers the smallest unsaturated result since reset.
//   Ports:
//     clk        - rising-edge clock
//     reset      - asynchronous, active-high reset
//     start      - per-lane start request (IDLE/DONE -> RUN)
//     stop       - per-lane stop request (RUN -> DONE)
//     clear      - per-lane return-to-idle request (DONE -> IDLE)
//     count      - per-lane elapsed units, lane i at [i*CNT_W +: CNT_W]
//     busy       - lane is in RUN
//     done       - one-cycle pulse after RUN -> DONE
//     sat        - lane count reached MAX_COUNT since its last start
//     best       - per-lane minimum unsaturated result
//     best_valid - best holds at least one result
module lane_timer
    import lane_timer_pkg::*;
#(
    parameter int LANES     = DEFAULT_LANES,
    parameter int TICK_DIV  = DEFAULT_TICK_DIV,
    parameter int CNT_W     = DEFAULT_CNT_W,
    parameter int MAX_COUNT = DEFAULT_MAX_COUNT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LANES-1:0]       start,
    input  logic [LANES-1:0]       stop,
    input  logic [LANES-1:0]       clear,
    output logic [LANES*CNT_W-1:0] count,
    output logic [LANES-1:0]       busy,
    output logic [LANES-1:0]       done,
    output logic [LANES-1:0]       sat,
    output logic [LANES*CNT_W-1:0] best,
    output logic [LANES-1:0]       best_valid
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

    for (genvar i = 0; i < LANES; i++) begin : g_lane

        lane_state_e      state_q, state_d;
        logic [CNT_W-1:0] count_q, count_d;
        logic [CNT_W-1:0] best_q, best_d;
        logic             sat_q, sat_d;
        logic             done_q, done_d;
        logic             busy_q, busy_d;
        logic             best_valid_q, best_valid_d;
        logic             run;
        logic             tick;

        assign run = (state_q == RUN);

        lane_tick_prescaler #(
            .TICK_DIV (TICK_DIV)
        ) u_prescaler (
            .clk   (clk),
            .reset (reset),
            .run   (run),
            .tick  (tick)
        );

        always_comb begin
            state_d      = state_q;
            count_d      = count_q;
            best_d       = best_q;
            sat_d        = sat_q;
            done_d       = 1'b0;
            best_valid_d = best_valid_q;

            unique case (state_q)
                IDLE, DONE: begin
                    // start wins over clear; stop means nothing here
                    if (start[i]) begin
                        state_d = RUN;
                        count_d = '0;
                        sat_d   = 1'b0;
                    end else if (clear[i]) begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    if (tick && (count_q < MAX_C)) begin
                        count_d = count_q + 1'b1;
                        if (count_d == MAX_C) begin
                            sat_d = 1'b1;
                        end
                    end
                    // The final result includes a tick landing on the stop
                    // edge, hence count_d/sat_d rather than the flops.
                    if (stop[i]) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        if (!sat_d && (!best_valid_q || (count_d < best_q))) begin
                            best_d       = count_d;
                            best_valid_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            busy_d = (state_d == RUN);
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q      <= IDLE;
                count_q      <= '0;
                best_q       <= MAX_C;
                sat_q        <= 1'b0;
                done_q       <= 1'b0;
                busy_q       <= 1'b0;
                best_valid_q <= 1'b0;
            end else begin
                state_q      <= state_d;
                count_q      <= count_d;
                best_q       <= best_d;
                sat_q        <= sat_d;
                done_q       <= done_d;
                busy_q       <= busy_d;
                best_valid_q <= best_valid_d;
            end
        end

        assign count[i*CNT_W +: CNT_W] = count_q;
        assign best[i*CNT_W +: CNT_W]  = best_q;
        assign busy[i]                 = busy_q;
        assign done[i]                 = done_q;
        assign sat[i]                  = sat_q;
        assign best_valid[i]           = best_valid_q;

    end

endmodule

// File: tb/tb_lane_timer.sv
// tb_lane_timer
//   Directed bench for lane_timer with LANES=2, TICK_DIV=4, CNT_W=4,
//   MAX_COUNT=9. Expected lane snapshots are queued as stimulus is driven and
//   compared field by field once the DUT has taken the corresponding edges.
module tb_lane_timer;

    localparam int LANES     = 2;
    localparam int TICK_DIV  = 4;
    localparam int CNT_W     = 4;
    localparam int MAX_COUNT = 9;

    logic                   clk;
    logic                   reset;
    logic [LANES-1:0]       start;
    logic [LANES-1:0]       stop;
    logic [LANES-1:0]       clear;
    logic [LANES*CNT_W-1:0] count;
    logic [LANES-1:0]       busy;
    logic [LANES-1:0]       done;
    logic [LANES-1:0]       sat;
    logic [LANES*CNT_W-1:0] best;
    logic [LANES-1:0]       best_valid;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string tag;
        int    lane;
        int    cnt;
        bit    bsy;
        bit    dn;
        bit    st;
        int    bst;
        bit    bv;
    } exp_t;

    exp_t sb[$];

    lane_timer #(
        .LANES     (LANES),
        .TICK_DIV  (TICK_DIV),
        .CNT_W     (CNT_W),
        .MAX_COUNT (MAX_COUNT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .sat        (sat),
        .best       (best),
        .best_valid (best_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runaway guard: the directed sequence is a few hundred cycles long.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Inputs change and outputs are sampled 1 time unit after a rising edge.
    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [1:0] st, input logic [1:0] sp, input logic [1:0] cl);
        start = st;
        stop  = sp;
        clear = cl;
        @(posedge clk);
        #1;
        start = '0;
        stop  = '0;
        clear = '0;
    endtask

    function automatic void expectLane(input string tag, input int lane, input int cnt,
                                       input bit bsy, input bit dn, input bit st,
                                       input int bst, input bit bv);
        exp_t e;
        e.tag  = tag;
        e.lane = lane;
        e.cnt  = cnt;
        e.bsy  = bsy;
        e.dn   = dn;
        e.st   = st;
        e.bst  = bst;
        e.bv   = bv;
        sb.push_back(e);
    endfunction

    task automatic compareField(input string tag, input string name,
                                input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s.%s observed=%0d expected=%0d", tag, name, obs, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        logic [CNT_W-1:0] c;
        logic [CNT_W-1:0] b;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            c = count[e.lane*CNT_W +: CNT_W];
            b = best[e.lane*CNT_W +: CNT_W];
            compareField(e.tag, "count",      {28'd0, c},                  e.cnt);
            compareField(e.tag, "busy",       {31'd0, busy[e.lane]},       {31'd0, e.bsy});
            compareField(e.tag, "done",       {31'd0, done[e.lane]},       {31'd0, e.dn});
            compareField(e.tag, "sat",        {31'd0, sat[e.lane]},        {31'd0, e.st});
            compareField(e.tag, "best",       {28'd0, b},                  e.bst);
            compareField(e.tag, "best_valid", {31'd0, best_valid[e.lane]}, {31'd0, e.bv});
        end
    endtask

    // One lane-1 measurement of n units, restarting directly from DONE.
    task automatic runLane1(input int n, input int expBest, input string tag);
        applyStimulus(2'b10, 2'b00, 2'b00);
        idleCycles(4 * n + 1);
        applyStimulus(2'b00, 2'b10, 2'b00);
        expectLane(tag, 1, n, 0, 1, 0, expBest, 1);
        checkOutput();
    endtask

    initial begin
        reset = 1'b1;
        start = '0;
        stop  = '0;
        clear = '0;
        idleCycles(2);
        expectLane("reset_l0", 0, 0, 0, 0, 0, 9, 0);
        expectLane("reset_l1", 1, 0, 0, 0, 0, 9, 0);
        checkOutput();
        reset = 1'b0;

        // Saturation on lane 0 straight after reset release.
        applyStimulus(2'b01, 2'b00, 2'b00);
        expectLane("sat_start", 0, 0, 1, 0, 0, 9, 0);
        checkOutput();
        idleCycles(35);
        expectLane("sat_tick8", 0, 8, 1, 0, 0, 9, 0);
        checkOutput();
        idleCycles(1);
        expectLane("sat_tick9", 0, 9, 1, 0, 1, 9, 0);
        checkOutput();
        idleCycles(20);
        expectLane("sat_hold", 0, 9, 1, 0, 1, 9, 0);
        checkOutput();
        applyStimulus(2'b00, 2'b01, 2'b00);
        expectLane("sat_stop", 0, 9, 0, 1, 1, 9, 0);
        checkOutput();
        idleCycles(1);
        expectLane("sat_done_end", 0, 9, 0, 0, 1, 9, 0);
        checkOutput();
        applyStimulus(2'b00, 2'b00, 2'b01);
        expectLane("sat_clear", 0, 9, 0, 0, 1, 9, 0);
        checkOutput();

        // Basic measurement: start at edge 0, stop sampled at edge 14.
        applyStimulus(2'b01, 2'b00, 2'b00);
        expectLane("m3_start", 0, 0, 1, 0, 0, 9, 0);
        expectLane("m3_l1_idle", 1, 0, 0, 0, 0, 9, 0);
        checkOutput();
        idleCycles(3);
        expectLane("m3_pre_tick", 0, 0, 1, 0, 0, 9, 0);
        checkOutput();
        idleCycles(1);
        expectLane("m3_first_tick", 0, 1, 1, 0, 0, 9, 0);
        checkOutput();
        idleCycles(9);
        expectLane("m3_edge13", 0, 3, 1, 0, 0, 9, 0);
        checkOutput();
        applyStimulus(2'b00, 2'b01, 2'b00);
        expectLane("m3_stop", 0, 3, 0, 1, 0, 3, 1);
        expectLane("m3_l1_untouched", 1, 0, 0, 0, 0, 9, 0);
        checkOutput();
        idleCycles(1);
        expectLane("m3_pulse_end", 0, 3, 0, 0, 0, 3, 1);
        checkOutput();

        // clear to IDLE keeps count; stop alone in IDLE does nothing.
        applyStimulus(2'b00, 2'b00, 2'b01);
        expectLane("clear_idle", 0, 3, 0, 0, 0, 3, 1);
        checkOutput();
        applyStimulus(2'b00, 2'b01, 2'b00);
        expectLane("stop_in_idle", 0, 3, 0, 0, 0, 3, 1);
        checkOutput();

        // start+stop together in IDLE enters RUN; clear in RUN is ignored;
        // stop on the edge where count steps 3->4 yields 4 (not < best 3).
        applyStimulus(2'b01, 2'b01, 2'b00);
        expectLane("start_and_stop", 0, 0, 1, 0, 0, 3, 1);
        checkOutput();
        applyStimulus(2'b00, 2'b00, 2'b01);
        expectLane("clear_in_run", 0, 0, 1, 0, 0, 3, 1);
        checkOutput();
        idleCycles(14);
        expectLane("edge15", 0, 3, 1, 0, 0, 3, 1);
        checkOutput();
        applyStimulus(2'b00, 2'b01, 2'b00);
        expectLane("stop_on_tick", 0, 4, 0, 1, 0, 3, 1);
        checkOutput();
        applyStimulus(2'b00, 2'b01, 2'b00);
        expectLane("stop_in_done", 0, 4, 0, 0, 0, 3, 1);
        checkOutput();

        // Lane 1 best tracking over restarts without clear.
        runLane1(5, 5, "l1_res5");
        runLane1(2, 2, "l1_res2");
        runLane1(7, 2, "l1_res7");

        // Reset in the middle of a lane-1 run at count 2.
        applyStimulus(2'b10, 2'b00, 2'b00);
        idleCycles(8);
        expectLane("pre_reset_run", 1, 2, 1, 0, 0, 2, 1);
        checkOutput();
        #3;
        reset = 1'b1;
        #1;
        expectLane("async_reset_l0", 0, 0, 0, 0, 0, 9, 0);
        expectLane("async_reset_l1", 1, 0, 0, 0, 0, 9, 0);
        checkOutput();
        idleCycles(2);
        reset = 1'b0;
        idleCycles(1);
        expectLane("post_reset_l1", 1, 0, 0, 0, 0, 9, 0);
        checkOutput();
        applyStimulus(2'b10, 2'b00, 2'b00);
        expectLane("first_edge_start", 1, 0, 1, 0, 0, 9, 0);
        checkOutput();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lane_timer.md
LANE_TIMER -- requirements
Module: lane_timer

Interface
REQ-001 Parameter LANES, default 2, number of independent timer lanes (1..8).
REQ-002 Parameter TICK_DIV, default 100000, clk cycles per count unit (>=2).
REQ-003 Parameter CNT_W, default 14, width of each lane count.
REQ-004 Parameter MAX_COUNT, default 9999, saturation value (< 2**CNT_W).
REQ-005 Port clk  input  1  rising-edge clock.
REQ-006 Port reset  input  1  asynchronous, active-high reset.
REQ-007 Port start  input  LANES  per-lane start request, level sampled each clk.
REQ-008 Port stop  input  LANES  per-lane stop request, level sampled each clk.
REQ-009 Port clear  input  LANES  per-lane return-to-idle request.
REQ-010 Port count  output  LANES*CNT_W  per-lane elapsed units, lane i at bits [i*CNT_W +: CNT_W].
REQ-011 Port busy  output  LANES  lane in RUN.
REQ-012 Port done  output  LANES  one-cycle pulse on RUN->DONE.
REQ-013 Port sat  output  LANES  lane count has reached MAX_COUNT since last start.
REQ-014 Port best  output  LANES*CNT_W  per-lane minimum unsaturated result.
REQ-015 Port best_valid  output  LANES  best holds at least one result.

Function
REQ-016 Each lane SHALL run a FSM with states IDLE, RUN, DONE; lanes fully independent.
REQ-017 IDLE: start -> RUN; count cleared to 0, sat cleared, lane prescaler cleared, same edge.
REQ-018 DONE: start -> RUN with the same clearing as REQ-017 (restart without clear).
REQ-019 RUN: stop -> DONE; start ignored; clear ignored.
REQ-020 DONE: clear (without start) -> IDLE; count holds its value in IDLE until next start.
REQ-021 Priority in IDLE/DONE: start over clear over stop; stop is ignored outside RUN.
REQ-022 Lane prescaler SHALL count 0..TICK_DIV-1 only in RUN and emit a tick on wrap; first tick TICK_DIV cycles after the edge entering RUN.
REQ-023 On tick, count SHALL increment if < MAX_COUNT, else hold; sat SHALL set on the edge count becomes MAX_COUNT.
REQ-024 A tick coinciding with the stop-sampling edge SHALL be counted; count is then frozen.
REQ-025 On RUN->DONE, if sat=0 and (best_valid=0 or final count < best), best <= final count and best_valid <= 1; saturated results never update best.
REQ-026 done SHALL assert for exactly the one cycle following the RUN->DONE edge.
REQ-027 busy SHALL be registered, high exactly while state=RUN.
REQ-028 best/best_valid persist across clear and restart; only reset clears them.

Reset
REQ-029 Reset SHALL immediately force all lanes to IDLE, prescalers 0, count 0, sat 0, done 0, busy 0, best = MAX_COUNT, best_valid 0.
REQ-030 Reset asserted mid-RUN SHALL abandon the measurement without done pulse or best update.
REQ-031 After reset deassertion the first clk edge SHALL process inputs normally.

Structure
REQ-032 Package lane_timer_pkg SHALL hold the lane state enum (IDLE, RUN, DONE) and the default parameter constants.
REQ-033 Sub-module lane_tick_prescaler (TICK_DIV param; inputs clk, reset, run; output tick) SHALL be instantiated once per lane; FSM, count and best logic live in a generate loop in lane_timer.
REQ-034 Prescaler width SHALL be $clog2(TICK_DIV); no combinational path from inputs to outputs.

Verification (LANES=2, TICK_DIV=4, MAX_COUNT=9, CNT_W=4 unless noted)
REQ-035 Lane0 start at cycle 0, stop sampled at cycle 14 -> count0=3, done0 pulse cycle 15, best0=3, best_valid0=1; lane1 untouched.
REQ-036 Lane0 run 60 cycles -> count0 holds 9, sat0=1 at the 9th tick; after stop best_valid0 stays 0.
REQ-037 Results 5 then 2 then 7 on lane1 (restart from DONE, no clear) -> best1 sequence 5,2,2.
REQ-038 start and stop both high in IDLE -> RUN; stop alone in IDLE/DONE -> no state change; clear in RUN ignored.
REQ-039 Reset pulsed mid-RUN with count=2 -> all outputs at reset values, no done pulse, best untouched-as-reset.
REQ-040 Stop sampled on the edge count steps 3->4 -> final count 4.
